// File: rtl/axil_pkg.sv
// Shared AXI4-Lite master definitions: response codes,
// bridge FSM states and the default protection value.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite master behind a valid/ready command port.
// Define AXIL_MASTER_ERRCNT_EN to build the saturating error counter.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [15:0]                 err_count,

  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]                  m_axil_awprot,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,

  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,

  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]                  m_axil_arprot,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,

  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  state_t state;
  state_t state_nx;

  logic                        aw_done;
  logic                        w_done;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  resp_t                       resp_q;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_fin;
  logic w_fin;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = m_axil_awvalid & m_axil_awready;
  assign w_hs   = m_axil_wvalid & m_axil_wready;
  assign b_hs   = m_axil_bvalid & m_axil_bready;
  assign ar_hs  = m_axil_arvalid & m_axil_arready;
  assign r_hs   = m_axil_rvalid & m_axil_rready;

  // AW and W may finish in either order or in the same cycle
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (cmd_hs)
               state_nx = cmd_write ? WRITE : READ;
      WRITE: if (aw_fin && w_fin)
               state_nx = WRESP;
      WRESP: if (b_hs)
               state_nx = RESP;
      READ:  if (ar_hs)
               state_nx = RDATA;
      RDATA: if (r_hs)
               state_nx = RESP;
      RESP:  if (rsp_ready)
               state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    rsp_valid      = 1'b0;
    unique case (state)
      IDLE:  cmd_ready = aresetn;
      WRITE: begin
        m_axil_awvalid = ~aw_done;
        m_axil_wvalid  = ~w_done;
      end
      WRESP: m_axil_bready  = 1'b1;
      READ:  m_axil_arvalid = 1'b1;
      RDATA: m_axil_rready  = 1'b1;
      RESP:  rsp_valid      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= OKAY;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WRITE) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == WRESP && b_hs) begin
        rdata_q <= '0;
        resp_q  <= resp_t'(m_axil_bresp);
      end
      if (state == RDATA && r_hs) begin
        rdata_q <= m_axil_rdata;
        resp_q  <= resp_t'(m_axil_rresp);
      end
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = PROT_DEFAULT;
  assign m_axil_arprot = PROT_DEFAULT;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

`ifdef AXIL_MASTER_ERRCNT_EN
  logic [15:0] err_q;
  logic        resp_err;

  // counted on the edge that enters RESP with a non-OKAY code
  assign resp_err = (state == WRESP && b_hs && m_axil_bresp != OKAY)
                  | (state == RDATA && r_hs && m_axil_rresp != OKAY);

  always_ff @(posedge aclk) begin
    if (!aresetn)
      err_q <= '0;
    else if (resp_err && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed + randomized bench for axil_master_bridge with a
// stallable AXI4-Lite slave and a word-memory reference model.
module tb_axil_master_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axil_master_bridge #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .err_count(err_count),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---------------- stallable slave ----------------
  int aw_stall = 0, w_stall = 0, ar_stall = 0;
  int b_delay = 0, r_delay = 0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic got_aw, got_w, got_ar;
  logic [15:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] smem [64];
  bit   [63:0] written;
  int b_count = 0;

  assign awready = !got_aw && aw_cnt >= aw_stall;
  assign wready  = !got_w && w_cnt >= w_stall;
  assign arready = !got_ar && ar_cnt >= ar_stall;
  assign bvalid  = got_aw && got_w && b_wait >= b_delay;
  assign rvalid  = got_ar && r_wait >= r_delay;
  assign bresp   = s_bresp;
  assign rresp   = s_rresp;
  assign rdata   = written[s_araddr[7:2]] ? smem[s_araddr[7:2]]
                                          : init_val(int'(s_araddr[7:2]));

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_wait <= 0; r_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
      s_awaddr <= '0; s_araddr <= '0;
      s_wdata <= '0; s_wstrb <= '0;
    end else begin
      if (awvalid && awready) begin
        got_aw <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (arvalid && arready) begin
        got_ar <= 1'b1; s_araddr <= araddr; ar_cnt <= 0;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (bvalid && bready) begin
        smem[s_awaddr[7:2]] <= merge(written[s_awaddr[7:2]]
                                     ? smem[s_awaddr[7:2]]
                                     : init_val(int'(s_awaddr[7:2])),
                                     s_wdata, s_wstrb);
        written[s_awaddr[7:2]] <= 1'b1;
        got_aw <= 1'b0; got_w <= 1'b0; b_wait <= 0;
        b_count <= b_count + 1;
      end else if (got_aw && got_w) b_wait <= b_wait + 1;
      if (rvalid && rready) begin
        got_ar <= 1'b0; r_wait <= 0;
      end else if (got_ar) r_wait <= r_wait + 1;
    end
  end

  // ---------------- handshake protocol monitor ----------------
  logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
  logic p_rst = 0;
  logic [15:0] p_awaddr, p_araddr;

  always @(negedge aclk) begin
    if (aresetn && p_rst) begin
      if (p_aw && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_aw && p_awr)  chk("aw_drop", awvalid, 0);
      if (p_w && !p_wr)   chk("w_hold", wvalid, 1);
      if (p_w && p_wr)    chk("w_drop", wvalid, 0);
      if (p_ar && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_ar && p_arr)  chk("ar_drop", arvalid, 0);
    end
    p_aw = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_w = wvalid; p_wr = wready;
    p_ar = arvalid; p_arr = arready; p_araddr = araddr;
    p_rst = aresetn;
  end

  // ---------------- reference model ----------------
  logic [31:0] rmem [64];
  int exp_err = 0;

  task automatic run_cmd(input bit wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input int hold, input string tag,
                         output int lat);
    int n, c0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    lat = -1;
    exp_r = wr ? s_bresp : s_rresp;
    exp_d = wr ? 32'h0 : rmem[a[7:2]];
    @(negedge aclk);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    c0 = cyc;
    @(negedge aclk);
    cmd_valid = 1'b0;
    if (wr)
      chk({tag, "_c1"}, {awvalid, wvalid, awaddr, wdata, wstrb, awprot},
          {1'b1, 1'b1, a, d, s, 3'b000});
    else
      chk({tag, "_c1"}, {arvalid, araddr, arprot}, {1'b1, a, 3'b000});
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    chk({tag, "_rspv"}, rsp_valid, 1);
    lat = cyc - c0;
    if (exp_r != 2'b00 && exp_err < 65535) exp_err++;
    chk({tag, "_rsp"}, {rsp_rdata, rsp_resp}, {exp_d, exp_r});
`ifdef AXIL_MASTER_ERRCNT_EN
    chk({tag, "_err"}, err_count, 16'(exp_err));
`else
    chk({tag, "_err"}, err_count, 0);
`endif
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 16'h0044; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(negedge aclk);
        chk({tag, "_hold"},
            {rsp_valid, rsp_rdata, rsp_resp, cmd_ready, awvalid, wvalid, arvalid},
            {1'b1, exp_d, exp_r, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    if (wr) rmem[a[7:2]] = merge(rmem[a[7:2]], d, s);
  endtask

  initial begin
    int lat, b0, n;
    bit wr;
    logic [15:0] a;
    for (int i = 0; i < 64; i++) rmem[i] = init_val(i);
    aresetn = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge aclk);
    chk("rst_hs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_data", {rsp_rdata, rsp_resp, err_count}, 0);
    chk("rst_addr", {awaddr, araddr, wdata, wstrb}, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_cmd_ready", cmd_ready, 1);

    run_cmd(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, "wr0", lat);
    chk("wr0_lat", 64'(lat), 3);
    run_cmd(0, 16'h0010, 32'h0, 4'h0, 0, "rd0", lat);
    chk("rd0_lat", 64'(lat), 3);

    run_cmd(1, 16'h0020, 32'hCAFEF00D, 4'hF, 0, "wr20", lat);
    ar_stall = 5; r_delay = 3;
    run_cmd(0, 16'h0020, 32'h0, 4'h0, 0, "rdstall", lat);
    chk("rdstall_data", rsp_rdata, 32'hCAFEF00D);
    chk("rdstall_lat", 64'(lat), 11);
    ar_stall = 0; r_delay = 0;

    aw_stall = 4; w_stall = 0; b0 = b_count;
    run_cmd(1, 16'h0030, 32'h0102_0304, 4'h5, 0, "w_first", lat);
    chk("w_first_b", 64'(b_count - b0), 1);
    chk("w_first_lat", 64'(lat), 7);
    aw_stall = 0; w_stall = 4; b0 = b_count;
    run_cmd(1, 16'h0034, 32'hA0B0_C0D0, 4'hA, 0, "aw_first", lat);
    chk("aw_first_b", 64'(b_count - b0), 1);
    chk("aw_first_lat", 64'(lat), 7);
    w_stall = 0;
    run_cmd(0, 16'h0030, 32'h0, 4'h0, 0, "rd30", lat);

    s_bresp = 2'b10;
    run_cmd(1, 16'h0040, 32'h5555_AAAA, 4'hF, 0, "wr_slverr", lat);
    s_bresp = 2'b00; s_rresp = 2'b11;
    run_cmd(0, 16'h0040, 32'h0, 4'h0, 0, "rd_decerr", lat);
    s_rresp = 2'b00;
`ifdef AXIL_MASTER_ERRCNT_EN
    chk("err_two", err_count, 2);
`else
    chk("err_two", err_count, 0);
`endif

    run_cmd(0, 16'h0034, 32'h0, 4'h0, 10, "hold", lat);

    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom);
      a = 16'($urandom) & 16'hFFFC;
      aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
      ar_stall = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      s_bresp = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
      s_rresp = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
      b0 = b_count;
      run_cmd(wr, a, $urandom, 4'($urandom), 0, "rand", lat);
      chk("rand_b", 64'(b_count - b0), wr ? 64'd1 : 64'd0);
    end
    aw_stall = 0; w_stall = 0; ar_stall = 0; r_delay = 0;
    s_bresp = 2'b00; s_rresp = 2'b00;

    b_delay = 10;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 16'h0050; cmd_wdata = 32'h7777_8888; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 50) begin @(negedge aclk); n++; end
    chk("mid_wresp", bready, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("mid_rst_valids",
        {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    aresetn = 1'b1;
    exp_err = 0;
    b_delay = 0;
    @(negedge aclk);
    chk("mid_rel", {cmd_ready, rsp_valid, err_count}, {1'b1, 1'b0, 16'h0});
    run_cmd(0, 16'h0050, 32'h0, 4'h0, 0, "post_rst", lat);
    chk("post_rst_lat", 64'(lat), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
